// File: rtl/brick_serializer_pkg.sv
// Shared definitions for the bit-serial datapath.
//   BRICK_BL     default brick width in bits
//   VAL_W        bits per value
//   PREC_BITS    width of the precision / bit-index fields
//   V_PER_BRICK  values per brick
//   state_e      serializer control state
package stripes_pkg;
    localparam int BRICK_BL    = 256;
    localparam int VAL_W       = 16;
    localparam int PREC_BITS   = 4;
    localparam int V_PER_BRICK = BRICK_BL / VAL_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/brick_serializer_bit_serial_lane.sv
// One brick's worth of value shift registers.
//   clk, rst_n  clock / async active-low reset
//   load        parallel load of load_data (has priority over shift)
//   shift       shift every VAL_W-bit value right by one
//   load_data   V values, value v at [v*VAL_W +: VAL_W]
//   lsb         bit 0 of every value (current bit-plane for this brick)
module bit_serial_lane
    import stripes_pkg::*;
#(
    parameter int V = V_PER_BRICK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [V*VAL_W-1:0] load_data,
    output logic [V-1:0]     lsb
);
    logic [V*VAL_W-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_data;
        end else if (shift) begin
            for (int v = 0; v < V; v++) begin
                sh_d[v*VAL_W +: VAL_W] = sh_q[v*VAL_W +: VAL_W] >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= sh_d;
    end

    always_comb begin
        lsb = '0;
        for (int v = 0; v < V; v++) begin
            lsb[v] = sh_q[v*VAL_W];
        end
    end
endmodule

// File: rtl/brick_serializer.sv
// Double-buffered bit-serial converter: takes a bundle of N_BRICKS bricks and
// emits it LSB-first, one bit of every value per plane, for p = i_prec+1 planes.
//   i_valid/i_ready/i_data/i_prec   bundle input (pending buffer)
//   o_valid/o_ready/o_bits          bit-plane output, o_bits[b*V+v] = bit k of value v, brick b
//   o_bit_idx                       k of the presented plane
//   o_first/o_last                  k == 0 / k == p-1
module brick_serializer
    import stripes_pkg::*;
#(
    parameter int BL       = BRICK_BL,
    parameter int N_BRICKS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [N_BRICKS*BL-1:0]   i_data,
    input  logic [PREC_BITS-1:0]     i_prec,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [N_BRICKS*(BL/VAL_W)-1:0] o_bits,
    output logic [PREC_BITS-1:0]     o_bit_idx,
    output logic                     o_first,
    output logic                     o_last
);
    localparam int V = BL / VAL_W;

    state_e                 state_q, state_d;
    logic                   pend_v_q, pend_v_d;
    logic [N_BRICKS*BL-1:0] pend_data_q, pend_data_d;
    logic [PREC_BITS-1:0]   pend_prec_q, pend_prec_d;
    logic [PREC_BITS-1:0]   prec_q, prec_d;
    logic [PREC_BITS-1:0]   k_q, k_d;
    logic                   load, shift;
    logic                   at_last;

    // Ready depends only on state, so no o_ready -> i_ready path exists.
    assign i_ready = ~pend_v_q;
    assign at_last = (k_q == prec_q);

    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_prec_d = pend_prec_q;
        prec_d      = prec_q;
        k_d         = k_q;
        load        = 1'b0;
        shift       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    load     = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (o_ready) begin
                    if (!at_last) begin
                        shift = 1'b1;
                        k_d   = k_q + PREC_BITS'(1);
                    end else if (pend_v_q) begin
                        load  = 1'b1;       // chain next bundle, no bubble
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            k_d      = '0;
            prec_d   = pend_prec_q;
            pend_v_d = 1'b0;
        end

        // Accept needs pend_v_q=0 and load needs pend_v_q=1: never both.
        if (i_valid && !pend_v_q) begin
            pend_v_d    = 1'b1;
            pend_data_d = i_data;
            pend_prec_d = i_prec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_prec_q <= '0;
            prec_q      <= '0;
            k_q         <= '0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_prec_q <= pend_prec_d;
            prec_q      <= prec_d;
            k_q         <= k_d;
        end
    end

    logic [N_BRICKS-1:0][V-1:0] lane_bits;

    for (genvar b = 0; b < N_BRICKS; b++) begin : g_lane
        bit_serial_lane #(.V(V)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .shift     (shift),
            .load_data (pend_data_q[b*BL +: BL]),
            .lsb       (lane_bits[b])
        );
    end

    // All outputs derive purely from flops.
    assign o_bits    = lane_bits;
    assign o_valid   = (state_q == SHIFT);
    assign o_bit_idx = k_q;
    assign o_first   = (state_q == SHIFT) && (k_q == '0);
    assign o_last    = (state_q == SHIFT) && at_last;
endmodule
